// File: rtl/imm_decode_stage.sv
// Fetch-to-execute decode stage: classifies the opcode into an immediate format and registers the
// sign-extended immediate with instr/pc behind a 2-entry skid buffer that has a flush path.

module immediate_decoder (
  input  logic [31:7] instr_i,
  input  logic [2:0]  type_i,
  output logic [31:0] imm_o
);

  // Assemble the immediate for each format, sign-extending from instr[31]
  always_comb begin
    imm_o = 32'd0;
    case (type_i)
      3'd0:    imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      3'd1:    imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      3'd2:    imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      3'd3:    imm_o = {instr_i[31:12], 12'd0};
      3'd4:    imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = 32'd0;
    endcase
  end

endmodule

module imm_decode_stage #(
  parameter int PC_WIDTH    = 32,
  parameter bit ZERO_NO_IMM = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [31:0]         out_imm,
  output logic [2:0]          out_imm_type,
  output logic                out_has_imm,
  output logic                out_illegal
);

  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_e;

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         imm;
    logic [2:0]          imm_type;
    logic                has_imm;
    logic                illegal;
  } entry_t;

  state_e      state_q, state_d;
  entry_t      main_q, skid_q, new_s;
  logic        in_ready_q, out_valid_q;
  logic [2:0]  cls_type_s;
  logic        cls_has_s, cls_ill_s;
  logic [31:0] dec_imm_s;
  logic        accept_s, pop_s;

  // Opcode classification; anything unrecognised decodes as type I so the decoder never sees a bad type
  always_comb begin
    cls_type_s = 3'd0;
    cls_has_s  = 1'b0;
    cls_ill_s  = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      cls_ill_s = 1'b1;
    end else begin
      case (in_instr[6:0])
        7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: begin
          cls_type_s = 3'd0; cls_has_s = 1'b1;
        end
        7'b0100011:             begin cls_type_s = 3'd1; cls_has_s = 1'b1; end
        7'b1100011:             begin cls_type_s = 3'd2; cls_has_s = 1'b1; end
        7'b0110111, 7'b0010111: begin cls_type_s = 3'd3; cls_has_s = 1'b1; end
        7'b1101111:             begin cls_type_s = 3'd4; cls_has_s = 1'b1; end
        7'b0110011:             begin cls_type_s = 3'd0; cls_has_s = 1'b0; end
        default:                begin cls_type_s = 3'd0; cls_ill_s = 1'b1; end
      endcase
    end
  end

  immediate_decoder u_dec (
    .instr_i (in_instr[31:7]),
    .type_i  (cls_type_s),
    .imm_o   (dec_imm_s)
  );

  // Entry as it would be captured on acceptance this cycle
  always_comb begin
    new_s.instr    = in_instr;
    new_s.pc       = in_pc;
    new_s.imm_type = cls_type_s;
    new_s.has_imm  = cls_has_s;
    new_s.illegal  = cls_ill_s;
    if (ZERO_NO_IMM && !cls_has_s) begin
      new_s.imm = 32'd0;
    end else begin
      new_s.imm = dec_imm_s;
    end
  end

  assign accept_s = in_valid & in_ready_q;
  assign pop_s    = out_valid_q & out_ready;

  // Occupancy next state; flush overrides any handshake in the same cycle
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: state_d = accept_s ? ST_ONE : ST_EMPTY;
        ST_ONE: begin
          if (accept_s && !pop_s) begin
            state_d = ST_TWO;
          end else if (!accept_s && pop_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO:   state_d = pop_s ? ST_ONE : ST_TWO;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // State, registered handshake outputs and slot data; slots keep stale data when not valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
      if (!flush) begin
        case (state_q)
          ST_EMPTY: if (accept_s) main_q <= new_s;
          ST_ONE: begin
            if (accept_s && pop_s) begin
              main_q <= new_s;
            end else if (accept_s) begin
              skid_q <= new_s;
            end
          end
          ST_TWO:   if (pop_s) main_q <= skid_q;
          default:  main_q <= main_q;
        endcase
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_instr    = main_q.instr;
  assign out_pc       = main_q.pc;
  assign out_imm      = main_q.imm;
  assign out_imm_type = main_q.imm_type;
  assign out_has_imm  = main_q.has_imm;
  assign out_illegal  = main_q.illegal;

endmodule
